// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the register-file port scheduler.
//   REG_AW   - register address width
//   NREG     - number of architectural registers
//   DW       - register data width
//   WF_WRITE - value of the active-low write enable that commits a write
//   WF_IDLE  - value of the write enable when no write takes place
package regfile_pkg;

  localparam int REG_AW = 5;
  localparam int NREG   = 32;
  localparam int DW     = 32;

  localparam logic WF_WRITE = 1'b0;
  localparam logic WF_IDLE  = 1'b1;

endpackage : regfile_pkg

// File: rtl/regfile_port_sched_chk.sv
// regfile_port_sched_chk: protocol assertions for the register-file scheduler.
//   clk, rst_n - clock and asynchronous active-low reset
//   wb_valid   - writeback requests
//   wb_ready   - writeback grants
//   rf_wf      - active-low register file write enable
module regfile_port_sched_chk #(
  parameter int NREQ = 3
) (
  input logic            clk,
  input logic            rst_n,
  input logic [NREQ-1:0] wb_valid,
  input logic [NREQ-1:0] wb_ready,
  input logic            rf_wf
);

  logic accept;
  assign accept = |(wb_valid & wb_ready);

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(wb_ready));

  a_grant_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    ((wb_ready & ~wb_valid) == '0));

  a_accept_writes: assert property (@(posedge clk) disable iff (!rst_n)
    accept |=> (rf_wf == 1'b0));

  a_idle_no_write: assert property (@(posedge clk) disable iff (!rst_n)
    !accept |=> (rf_wf == 1'b1));

endmodule : regfile_port_sched_chk

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req    in  NREQ  request vector
//   ptr    in  PW    highest-priority requester for this cycle
//   grant  out NREQ  one-hot grant (all zero when no request)
//   winner out PW    index of the granted requester (0 when no grant)
//   any    out 1     at least one request present
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   winner,
  output logic            any
);

  logic found;

  // Scan from ptr upward with wrap-around; the first active request wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = idx[PW-1:0];
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
    any = found;
  end

endmodule : rr_arbiter

// File: rtl/regfile_port_sched.sv
// regfile_port_sched: schedules the register file's single write port and
// its read port. Writeback requesters are arbitrated round-robin onto the
// write port (one registered write stage), and a per-register busy
// scoreboard produces RAW stalls for decode and WAW stalls for issue.
//   clk, rst_n          core clock, asynchronous active-low reset
//   wb_valid/addr/data  writeback requests (slice i per requester)
//   wb_ready            one-hot grant, transfer on valid & ready
//   iss_valid/iss_ws    issue of an instruction writing iss_ws
//   iss_ready           0 when iss_ws is already busy (WAW stall)
//   rd_req/rs1/rs2      operand read request
//   rd_stall            RAW stall on either source register
//   rf_rf               read enable (active-high)
//   rf_wf               write enable (active-low)
//   rf_ws/rf_wd         registered write address / data
//   rf_rs1/rf_rs2       read addresses (pass-through)
module regfile_port_sched #(
  parameter int NREQ = 3,
  parameter int NREG = regfile_pkg::NREG,
  parameter int DW   = regfile_pkg::DW
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NREQ-1:0]                   wb_valid,
  input  logic [NREQ*regfile_pkg::REG_AW-1:0] wb_addr,
  input  logic [NREQ*DW-1:0]                wb_data,
  output logic [NREQ-1:0]                   wb_ready,
  input  logic                              iss_valid,
  input  logic [regfile_pkg::REG_AW-1:0]    iss_ws,
  output logic                              iss_ready,
  input  logic                              rd_req,
  input  logic [regfile_pkg::REG_AW-1:0]    rs1,
  input  logic [regfile_pkg::REG_AW-1:0]    rs2,
  output logic                              rd_stall,
  output logic                              rf_rf,
  output logic                              rf_wf,
  output logic [regfile_pkg::REG_AW-1:0]    rf_ws,
  output logic [DW-1:0]                     rf_wd,
  output logic [regfile_pkg::REG_AW-1:0]    rf_rs1,
  output logic [regfile_pkg::REG_AW-1:0]    rf_rs2
);

  import regfile_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     rr_ptr_r;
  logic [NREQ-1:0]   grant_s;
  logic [PW-1:0]     winner_s;
  logic              any_s;
  logic              accept_s;
  logic [REG_AW-1:0] sel_addr_s;
  logic [DW-1:0]     sel_data_s;

  logic              wf_r;
  logic [REG_AW-1:0] ws_r;
  logic [DW-1:0]     wd_r;

  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   set_vec_s;
  logic [NREG-1:0]   clr_vec_s;
  logic [NREG-1:0]   busy_next_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req    (wb_valid),
    .ptr    (rr_ptr_r),
    .grant  (grant_s),
    .winner (winner_s),
    .any    (any_s)
  );

  // Grants are forced low while reset is held so requesters never see a
  // transfer that the write stage would drop.
  assign wb_ready = rst_n ? grant_s : '0;
  assign accept_s = any_s & rst_n;

  // Select the winning requester's address and data; the grant is one-hot,
  // so an AND-OR mux is sufficient.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr_s = sel_addr_s | (wb_addr[i*REG_AW +: REG_AW] & {REG_AW{grant_s[i]}});
      sel_data_s = sel_data_s | (wb_data[i*DW +: DW] & {DW{grant_s[i]}});
    end
  end

  // Write stage and round-robin pointer: an accept in cycle N drives the
  // write port during cycle N+1; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wf_r     <= WF_IDLE;
      ws_r     <= '0;
      wd_r     <= '0;
      rr_ptr_r <= '0;
    end else if (accept_s) begin
      wf_r     <= WF_WRITE;
      ws_r     <= sel_addr_s;
      wd_r     <= sel_data_s;
      rr_ptr_r <= (winner_s == PW'(NREQ - 1)) ? '0 : PW'(winner_s + PW'(1));
    end else begin
      wf_r     <= WF_IDLE;
      ws_r     <= ws_r;
      wd_r     <= wd_r;
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign iss_ready = ~busy_r[iss_ws];

  // Scoreboard next state: the write in flight clears its register, an
  // accepted issue sets its destination. Clear is applied first so a
  // same-edge set of the same register wins.
  always_comb begin
    set_vec_s          = '0;
    clr_vec_s          = '0;
    set_vec_s[iss_ws]  = iss_valid & iss_ready;
    clr_vec_s[ws_r]    = (wf_r == WF_WRITE);
    busy_next_s        = (busy_r & ~clr_vec_s) | set_vec_s;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // A register written in cycle N+1 is cleared at the end of that cycle, so
  // reads of it stop stalling from cycle N+2 (no bypass path).
  assign rd_stall = rd_req & (busy_r[rs1] | busy_r[rs2]);
  assign rf_rf    = rst_n & rd_req & ~rd_stall;

  assign rf_wf  = wf_r;
  assign rf_ws  = ws_r;
  assign rf_wd  = wd_r;
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  regfile_port_sched_chk #(
    .NREQ (NREQ)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .rf_wf    (rf_wf)
  );

endmodule : regfile_port_sched

// File: tb/tb_regfile_port_sched.sv
// tb_regfile_port_sched: scoreboard bench for regfile_port_sched.
// A reference model of the arbiter and busy scoreboard predicts grants and
// stalls; accepted writes are queued and popped when the write port fires.
module tb_regfile_port_sched;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   wb_valid;
  logic [NREQ*AW-1:0] wb_addr;
  logic [NREQ*DW-1:0] wb_data;
  logic [NREQ-1:0]   wb_ready;
  logic              iss_valid;
  logic [AW-1:0]     iss_ws;
  logic              iss_ready;
  logic              rd_req;
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic              rd_stall;
  logic              rf_rf;
  logic              rf_wf;
  logic [AW-1:0]     rf_ws;
  logic [DW-1:0]     rf_wd;
  logic [AW-1:0]     rf_rs1;
  logic [AW-1:0]     rf_rs2;

  regfile_port_sched #(.NREQ(NREQ), .NREG(32), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .iss_valid (iss_valid),
    .iss_ws    (iss_ws),
    .iss_ready (iss_ready),
    .rd_req    (rd_req),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd_stall  (rd_stall),
    .rf_rf     (rf_rf),
    .rf_wf     (rf_wf),
    .rf_ws     (rf_ws),
    .rf_wd     (rf_wd),
    .rf_rs1    (rf_rs1),
    .rf_rs2    (rf_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          m_ptr;
  logic [31:0] m_busy;
  logic [2:0]  last_grant;
  int          total;
  int          bad;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr      = 0;
    m_busy     = '0;
    last_grant = '0;
  endtask

  task automatic idle_inputs();
    wb_valid  = '0;
    wb_addr   = '0;
    wb_data   = '0;
    iss_valid = 1'b0;
    iss_ws    = '0;
    rd_req    = 1'b0;
    rs1       = '0;
    rs2       = '0;
  endtask

  // Inputs are already applied (posedge + 1); check mid-cycle, advance the
  // model for the coming edge, then step to just after that edge.
  task automatic run_cycle();
    logic [2:0]    eg;
    int            win;
    wr_t           e;
    logic          cw;
    logic [AW-1:0] cws;
    logic          set_ok;
    logic          exp_stall;
    #2;
    eg  = '0;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (win < 0 && wb_valid[idx]) begin
        win     = idx;
        eg[idx] = 1'b1;
      end
    end
    check_eq("wb_ready", wb_ready, eg);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("rf_wf_write", rf_wf, 1'b0);
      check_eq("rf_ws", rf_ws, e.addr);
      check_eq("rf_wd", rf_wd, e.data);
      cw  = 1'b1;
      cws = e.addr;
    end else begin
      check_eq("rf_wf_idle", rf_wf, 1'b1);
      cw  = 1'b0;
      cws = '0;
    end
    exp_stall = rd_req && (m_busy[rs1] || m_busy[rs2]);
    check_eq("iss_ready", iss_ready, !m_busy[iss_ws]);
    check_eq("rd_stall", rd_stall, exp_stall);
    check_eq("rf_rf", rf_rf, rd_req && !exp_stall);
    check_eq("rf_rs1", rf_rs1, rs1);
    check_eq("rf_rs2", rf_rs2, rs2);
    if (win >= 0) begin
      e.addr = wb_addr[win*AW +: AW];
      e.data = wb_data[win*DW +: DW];
      exp_q.push_back(e);
      m_ptr = (win + 1) % NREQ;
    end
    set_ok = iss_valid && !m_busy[iss_ws];
    if (cw) m_busy[cws] = 1'b0;
    if (set_ok) m_busy[iss_ws] = 1'b1;
    last_grant = eg;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();

    // Reset held with every request asserted.
    rst_n     = 1'b0;
    wb_valid  = 3'b111;
    wb_addr   = {5'd2, 5'd1, 5'd4};
    wb_data   = {32'h33333333, 32'h22222222, 32'h11111111};
    iss_valid = 1'b1;
    iss_ws    = 5'd4;
    rd_req    = 1'b1;
    rs1       = 5'd4;
    rs2       = 5'd1;
    #23;
    check_eq("rst_wb_ready", wb_ready, 3'b000);
    check_eq("rst_rf_wf", rf_wf, 1'b1);
    check_eq("rst_rf_rf", rf_rf, 1'b0);
    check_eq("rst_iss_ready", iss_ready, 1'b1);
    check_eq("rst_rf_ws", rf_ws, 5'd0);
    check_eq("rst_rf_wd", rf_wd, 32'd0);
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single write from requester 0.
    wb_valid = 3'b001;
    wb_addr[4:0]  = 5'd5;
    wb_data[31:0] = 32'h3F000000;
    run_cycle();
    wb_valid = 3'b000;
    run_cycle();
    run_cycle();

    // Round-robin with all three requesters held valid.
    do_reset();
    wb_valid = 3'b111;
    wb_addr  = {5'd12, 5'd11, 5'd10};
    wb_data  = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    for (int n = 0; n < 6; n++) run_cycle();
    wb_valid = 3'b000;
    run_cycle();
    run_cycle();

    // RAW: r3 busy until written back.
    iss_valid = 1'b1;
    iss_ws    = 5'd3;
    run_cycle();
    iss_valid = 1'b0;
    rd_req    = 1'b1;
    rs1       = 5'd3;
    rs2       = 5'd0;
    run_cycle();
    run_cycle();
    wb_valid = 3'b010;
    wb_addr[9:5]   = 5'd3;
    wb_data[63:32] = 32'h0BADF00D;
    run_cycle();
    wb_valid = 3'b000;
    run_cycle();
    run_cycle();
    rd_req = 1'b0;

    // WAW on r7, then same-edge clear and set of r7.
    iss_valid = 1'b1;
    iss_ws    = 5'd7;
    run_cycle();
    run_cycle();
    iss_valid = 1'b0;
    wb_valid  = 3'b100;
    wb_addr[14:10] = 5'd7;
    wb_data[95:64] = 32'hA5A5A5A5;
    run_cycle();
    wb_valid = 3'b000;
    run_cycle();
    run_cycle();
    wb_valid = 3'b100;
    wb_data[95:64] = 32'h5A5A5A5A;
    run_cycle();
    wb_valid  = 3'b000;
    iss_valid = 1'b1;
    run_cycle();
    iss_valid = 1'b0;
    rd_req    = 1'b1;
    rs1       = 5'd0;
    rs2       = 5'd7;
    run_cycle();

    // Asynchronous reset while a write is on the port.
    wb_valid = 3'b001;
    wb_addr[4:0]  = 5'd9;
    wb_data[31:0] = 32'h12345678;
    run_cycle();
    wb_valid = 3'b000;
    #2;
    check_eq("pre_rst_rf_wf", rf_wf, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_rf_wf", rf_wf, 1'b1);
    check_eq("async_rst_iss_ready", iss_ready, 1'b1);
    check_eq("async_rst_rd_stall", rd_stall, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycle();

    // Random traffic; requesters hold their request until granted.
    idle_inputs();
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(wb_valid[i] && !last_grant[i])) begin
          wb_valid[i]             = 1'($urandom_range(0, 1));
          wb_addr[i*AW +: AW]     = 5'($urandom_range(0, 7));
          wb_data[i*DW +: DW]     = $urandom;
        end
      end
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_ws    = 5'($urandom_range(0, 7));
      rd_req    = 1'($urandom_range(0, 1));
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      run_cycle();
    end
    idle_inputs();
    run_cycle();
    run_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_port_sched
